// File: rtl/r_shifter_pipe.sv
// ----------------------------------------------------------------------------
// r_shifter_pipe
//   Two-stage pipelined right shifter used for FPU operand alignment. It shifts
//   the smaller operand's mantissa right by the exponent difference. It also
//   produces the guard bit (first bit shifted out) and the sticky bit (OR of
//   every bit below the guard) for the rounding logic downstream.
//
//   Stage 1 applies the fine shift (shamt[2:0]). It keeps the first bit that
//   drops out and the OR of the rest of the dropped bits.
//   Stage 2 applies the coarse shift (shamt[5:3]*8). It then completes the
//   guard and sticky bits.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      input operation valid
//   in_ready   out  1      an input is accepted this cycle when in_valid=1
//   in_data    in   32     value to shift
//   in_shamt   in   6      shift amount 0..63
//   in_arith   in   1      1 = sign-fill, 0 = zero-fill
//   in_tag     in   TAG_W  opaque tag, passed through
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts the result
//   out_data   out  32     shifted value
//   out_guard  out  1      first bit shifted out
//   out_sticky out  1      OR of all bits below the guard bit
//   out_tag    out  TAG_W  tag of this result
//
// Handshake: a transfer occurs on a side when its valid and ready are both 1
// at a rising edge. A stage advances when it is empty or when its consumer
// takes its contents this cycle. The stage 2 register is the output register.
// in_ready depends combinationally on out_ready and never on in_valid.
// ----------------------------------------------------------------------------
module r_shifter_pipe #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [5:0]       in_shamt,
    input  logic             in_arith,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_guard,
    output logic             out_sticky,
    output logic [TAG_W-1:0] out_tag
);

    // Stage 1 state
    logic             s1_valid;
    logic [63:0]      s1_val;     // extended operand after the fine shift
    logic             s1_guard;   // last bit dropped by the fine shift
    logic             s1_sticky;  // OR of the bits dropped below s1_guard
    logic [2:0]       s1_k;       // pending coarse shift, in bytes
    logic [TAG_W-1:0] s1_tag;

    logic s1_adv;
    logic s2_adv;

    assign s2_adv    = !out_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    // in_ready is held at 0 while reset is asserted.
    assign in_ready  = rst_n && s1_adv;

    // ------------------------------------------------------------------
    // Stage 1 combinational: fine shift
    // The operand is widened to 64 bits. Eight zero bits are appended
    // below it to catch the bits that the 0..7 shift drops. The arithmetic
    // shift replicates bit 63, which is the sign bit for arith and 0 for
    // logical, so one shifter serves both modes.
    // ------------------------------------------------------------------
    logic [63:0] ext_in;
    logic [71:0] fine;

    always_comb begin
        ext_in = in_arith ? {{32{in_data[31]}}, in_data} : {32'b0, in_data};
        fine   = $signed({ext_in, 8'b0}) >>> in_shamt[2:0];
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: coarse shift and final guard/sticky
    // When the coarse shift is nonzero, bit 8k-1 of s1_val becomes the
    // guard. The bits below it join the sticky, and so do all bits that
    // stage 1 dropped.
    // ------------------------------------------------------------------
    logic [5:0]  byte_sh;
    logic [5:0]  guard_pos;
    logic [63:0] guard_mask;
    logic [63:0] coarse;
    logic        s2_guard_nx;
    logic        s2_sticky_nx;

    always_comb begin
        byte_sh      = {s1_k, 3'b000};
        guard_pos    = byte_sh - 6'd1;
        guard_mask   = 64'd1 << guard_pos;
        coarse       = $signed(s1_val) >>> byte_sh;
        s2_guard_nx  = s1_guard;
        s2_sticky_nx = s1_sticky;
        if (s1_k != 3'd0) begin
            s2_guard_nx  = |(s1_val & guard_mask);
            s2_sticky_nx = (|(s1_val & (guard_mask - 64'd1))) | s1_guard | s1_sticky;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_val    <= '0;
            s1_guard  <= 1'b0;
            s1_sticky <= 1'b0;
            s1_k      <= '0;
            s1_tag    <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_val    <= fine[71:8];
                s1_guard  <= fine[7];
                s1_sticky <= |fine[6:0];
                s1_k      <= in_shamt[5:3];
                s1_tag    <= in_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 / output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_guard  <= 1'b0;
            out_sticky <= 1'b0;
            out_tag    <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data   <= coarse[31:0];
                out_guard  <= s2_guard_nx;
                out_sticky <= s2_sticky_nx;
                out_tag    <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_r_shifter_pipe.sv
// ----------------------------------------------------------------------------
// tb_r_shifter_pipe
//   Directed bench for r_shifter_pipe. A table of operations with
//   hand-computed results feeds an expected queue. A negedge monitor pops the
//   queue on every output transfer.
// ----------------------------------------------------------------------------
module tb_r_shifter_pipe;

    localparam int TAG_W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic [5:0]       in_shamt;
    logic             in_arith;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_guard;
    logic             out_sticky;
    logic [TAG_W-1:0] out_tag;

    r_shifter_pipe #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .in_arith   (in_arith),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_guard  (out_guard),
        .out_sticky (out_sticky),
        .out_tag    (out_tag)
    );

    // ---------------- vector table ----------------
    logic [31:0] v_data   [8];
    logic [5:0]  v_shamt  [8];
    logic        v_arith  [8];
    logic [31:0] v_edata  [8];
    logic        v_eguard [8];
    logic        v_estick [8];

    // ---------------- scoreboard ----------------
    // packing: {tag[3:0], sticky, guard, data[31:0]}
    logic [37:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int n_in   = 0;
    int n_out  = 0;
    int n_wait = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [37:0] e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_output", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_data",   64'(out_data),   64'(e[31:0]));
                check("out_guard",  64'(out_guard),  64'(e[32]));
                check("out_sticky", 64'(out_sticky), 64'(e[33]));
                check("out_tag",    64'(out_tag),    64'(e[37:34]));
            end
            n_out++;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
    task automatic send(input int idx, input logic [TAG_W-1:0] tag);
        logic acc;
        int   waited;
        in_valid = 1'b1;
        in_data  = v_data[idx];
        in_shamt = v_shamt[idx];
        in_arith = v_arith[idx];
        in_tag   = tag;
        waited   = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) break;
            waited++;
        end
        n_wait += waited;
        exp_q.push_back({tag, v_estick[idx], v_eguard[idx], v_edata[idx]});
        n_in++;
        #1;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        v_data[0] = 32'h8000_0001; v_shamt[0] = 6'd1;  v_arith[0] = 1'b0;
        v_edata[0] = 32'h4000_0000; v_eguard[0] = 1'b1; v_estick[0] = 1'b0;
        v_data[1] = 32'h8000_0007; v_shamt[1] = 6'd3;  v_arith[1] = 1'b1;
        v_edata[1] = 32'hF000_0000; v_eguard[1] = 1'b1; v_estick[1] = 1'b1;
        v_data[2] = 32'h1234_5678; v_shamt[2] = 6'd40; v_arith[2] = 1'b0;
        v_edata[2] = 32'h0000_0000; v_eguard[2] = 1'b0; v_estick[2] = 1'b1;
        v_data[3] = 32'h1234_5678; v_shamt[3] = 6'd0;  v_arith[3] = 1'b0;
        v_edata[3] = 32'h1234_5678; v_eguard[3] = 1'b0; v_estick[3] = 1'b0;
        v_data[4] = 32'h8000_0000; v_shamt[4] = 6'd32; v_arith[4] = 1'b0;
        v_edata[4] = 32'h0000_0000; v_eguard[4] = 1'b1; v_estick[4] = 1'b0;
        v_data[5] = 32'h8000_0000; v_shamt[5] = 6'd63; v_arith[5] = 1'b1;
        v_edata[5] = 32'hFFFF_FFFF; v_eguard[5] = 1'b1; v_estick[5] = 1'b1;
        v_data[6] = 32'h8000_0000; v_shamt[6] = 6'd8;  v_arith[6] = 1'b1;
        v_edata[6] = 32'hFF80_0000; v_eguard[6] = 1'b0; v_estick[6] = 1'b0;
        v_data[7] = 32'h0000_00FF; v_shamt[7] = 6'd4;  v_arith[7] = 1'b0;
        v_edata[7] = 32'h0000_000F; v_eguard[7] = 1'b1; v_estick[7] = 1'b1;

        // Reset: inputs active during reset must be ignored.
        rst_n = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_shamt = 6'd5;
        in_arith = 1'b1; in_tag = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",   64'(in_ready),   64'd0);
        check("rst_out_valid",  64'(out_valid),  64'd0);
        check("rst_out_data",   64'(out_data),   64'd0);
        check("rst_out_guard",  64'(out_guard),  64'd0);
        check("rst_out_sticky", 64'(out_sticky), 64'd0);
        check("rst_out_tag",    64'(out_tag),    64'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        check("post_rst_no_output", 64'(out_valid), 64'd0);

        // Single ops: latency 2 and the directed boundary vectors.
        for (int i = 0; i < 8; i++) begin
            send(i, 4'(i));
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            check("latency", 64'(lat), 64'd2);
            @(posedge clk); #1;
        end
        drain();

        // Back-to-back stream, tags 0..7, no stalls expected.
        n_wait = 0;
        for (int i = 0; i < 8; i++) send(i, 4'(i));
        in_valid = 1'b0;
        check("stream_stalls", 64'(n_wait), 64'd0);
        drain();

        // Fill the pipe with out_ready low, hold it for 5 cycles.
        out_ready = 1'b0;
        send(0, 4'd8);
        send(1, 4'd9);
        in_valid = 1'b0;
        check("full_in_ready",  64'(in_ready),  64'd0);
        check("full_out_valid", 64'(out_valid), 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("stall_in_ready",  64'(in_ready),  64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_out_data",  64'(out_data),  64'(exp_q[0][31:0]));
            check("stall_out_tag",   64'(out_tag),   64'(exp_q[0][37:34]));
        end
        // Full pipe: out_ready and in_valid together move one op out and one in.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        #1;
        check("full_pass_in_ready", 64'(in_ready), 64'd1);
        send(2, 4'd10);
        in_valid = 1'b0;
        check("full_pass_occupancy", 64'(exp_q.size()), 64'd2);
        drain();

        // Reset with two ops in flight: both are discarded.
        out_ready = 1'b0;
        send(3, 4'd11);
        send(4, 4'd12);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_out_valid",  64'(out_valid),  64'd0);
        check("midrst_out_data",   64'(out_data),   64'd0);
        check("midrst_out_guard",  64'(out_guard),  64'd0);
        check("midrst_out_sticky", 64'(out_sticky), 64'd0);
        check("midrst_out_tag",    64'(out_tag),    64'd0);
        check("midrst_in_ready",   64'(in_ready),   64'd0);
        n_in -= exp_q.size();
        exp_q.delete();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("midrst_no_stale", 64'(out_valid), 64'd0);
        end
        send(5, 4'd13);
        in_valid = 1'b0;
        drain();

        check("in_out_count", 64'(n_out), 64'(n_in));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
